// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed 4-digit BCD to 7-segment scanner with frame-synchronous update
module bcd_display_scanner #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);
    logic [15:0] presc_q, presc_d, disp_q, disp_d, pend_q, pend_d;
    logic [1:0]  idx_q, idx_d;
    logic        pv_q, pv_d, err_q, err_d;
    logic        tick, wrap, bad, blank;
    logic [3:0]  dig, zero;
    logic [6:0]  glyph;
    // any captured nibble above 9 is not BCD
    always_comb begin
        bad = 1'b0;
        for (int k = 0; k < 4; k++) bad = bad | (bcd_in[4*k +: 4] > 4'd9);
    end
    // scan timing and frame-synchronous display update; a load on the wrap edge bypasses pending
    always_comb begin
        tick    = presc_q == LAST;
        wrap    = tick && idx_q == 2'd3;
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        disp_d  = (wrap && load) ? bcd_in : (wrap && pv_q) ? pend_q : disp_q;
        pend_d  = load ? bcd_in : pend_q;
        pv_d    = load ? !wrap : (wrap ? 1'b0 : pv_q);
        err_d   = err_q | (load & bad);
    end
    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            err_q   <= err_d;
        end
    end
    // blank a digit when it and all higher digits are zero; dash nibbles are non-zero
    always_comb begin
        dig = disp_q[{idx_q, 2'b00} +: 4];
        for (int k = 0; k < 4; k++) zero[k] = disp_q[4*k +: 4] == 4'd0;
        blank = blank_lz && ((idx_q == 2'd3 && zero[3]) ||
                             (idx_q == 2'd2 && &zero[3:2]) ||
                             (idx_q == 2'd1 && &zero[3:1]));
    end
    // segment glyphs, bit0 = a; non-BCD shows a dash
    always_comb begin
        case (dig)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
    end
    assign seg = blank ? 7'h00 : glyph;
    assign an  = 4'b0001 << idx_q;
    assign err = err_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed scoreboard bench for the BCD display scanner
module tb_bcd_display_scanner;
    localparam int P = 4;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;
    int checks = 0, errors = 0;
    typedef struct packed {logic [3:0] an; logic [6:0] seg;} exp_t;
    exp_t sb[$];

    bcd_display_scanner #(.PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
        .blank_lz(blank_lz), .seg(seg), .an(an), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
        sb.push_back(exp_t'{an: 4'b0001, seg: s0});
        sb.push_back(exp_t'{an: 4'b0010, seg: s1});
        sb.push_back(exp_t'{an: 4'b0100, seg: s2});
        sb.push_back(exp_t'{an: 4'b1000, seg: s3});
    endtask

    task automatic wait_an(input logic [3:0] v, input bit eq);
        int n = 0;
        while (((an === v) != eq) && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 64) else begin
            errors++;
            $error("FAIL wait_an observed=%b expected=%b eq=%0d", an, v, eq);
        end
    endtask

    task automatic check_frame(input string tag, input bit nosync);
        exp_t e;
        if (!nosync) begin
            wait_an(4'b0001, 1'b0);
            wait_an(4'b0001, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) repeat (P) @(negedge clk);
            if (sb.size() == 0) begin
                $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
                $fatal(1);
            end
            e = sb.pop_front();
            chk({tag, "_an"}, 16'(an), 16'(e.an));
            chk({tag, "_seg"}, 16'(seg), 16'(e.seg));
        end
    endtask

    task automatic load_pulse(input logic [15:0] v);
        bcd_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_an", 16'(an), 16'h1);
        chk("rst_seg", 16'(seg), 16'h3F);
        chk("rst_err", 16'(err), 16'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel3_an", 16'(an), 16'h1);
        @(negedge clk);
        chk("rel4_an", 16'(an), 16'h2);
        // pending load mid-frame must not tear the display
        load_pulse(16'h1234);
        chk("hold_an", 16'(an), 16'h2);
        chk("hold_seg", 16'(seg), 16'h3F);
        wait_an(4'b1000, 1'b1);
        chk("hold3_seg", 16'(seg), 16'h3F);
        push4(7'h66, 7'h4F, 7'h5B, 7'h06);
        check_frame("f1234", 1'b0);
        chk("err_clean", 16'(err), 16'h0);
        // leading-zero blanking on and off
        blank_lz = 1'b1;
        load_pulse(16'h0070);
        push4(7'h3F, 7'h07, 7'h00, 7'h00);
        check_frame("f0070b", 1'b0);
        blank_lz = 1'b0;
        push4(7'h3F, 7'h07, 7'h3F, 7'h3F);
        check_frame("f0070", 1'b0);
        // non-BCD nibble: dash and sticky error
        load_pulse(16'h12A4);
        chk("err_set", 16'(err), 16'h1);
        push4(7'h66, 7'h40, 7'h5B, 7'h06);
        check_frame("f12A4", 1'b0);
        load_pulse(16'h0003);
        chk("err_sticky", 16'(err), 16'h1);
        blank_lz = 1'b1;
        push4(7'h4F, 7'h00, 7'h00, 7'h00);
        check_frame("f0003b", 1'b0);
        load_pulse(16'h0A04);
        push4(7'h66, 7'h3F, 7'h40, 7'h00);
        check_frame("f0A04b", 1'b0);
        // load on the wrap edge overrides pending 1111
        blank_lz = 1'b0;
        wait_an(4'b0001, 1'b1);
        load_pulse(16'h1111);
        wait_an(4'b1000, 1'b1);
        repeat (P - 1) @(negedge clk);
        load_pulse(16'h5678);
        push4(7'h7F, 7'h07, 7'h7D, 7'h6D);
        push4(7'h7F, 7'h07, 7'h7D, 7'h6D);
        check_frame("wrap1", 1'b1);
        check_frame("wrap2", 1'b0);
        // two loads in one frame: last wins
        wait_an(4'b0001, 1'b1);
        load_pulse(16'h0001);
        repeat (2) @(negedge clk);
        load_pulse(16'h0002);
        blank_lz = 1'b1;
        push4(7'h5B, 7'h00, 7'h00, 7'h00);
        check_frame("two", 1'b0);
        // asynchronous reset mid-frame discards pending data
        blank_lz = 1'b0;
        wait_an(4'b0001, 1'b1);
        load_pulse(16'h9999);
        wait_an(4'b0100, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_an", 16'(an), 16'h1);
        chk("arst_seg", 16'(seg), 16'h3F);
        chk("arst_err", 16'(err), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("arel3_an", 16'(an), 16'h1);
        @(negedge clk);
        chk("arel4_an", 16'(an), 16'h2);
        push4(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        check_frame("postrst", 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter PRESCALE, default 4: clk cycles each digit is displayed; legal values are 1..65535.
REQ-002 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-low reset.
REQ-004 Port load, input, 1: strobe that captures bcd_in on the rising clk edge where load=1.
REQ-005 Port bcd_in, input, 16: four BCD digits, digit k = bcd_in[4k+3:4k], digit 0 least significant (fed by cascaded mod-10 counters).
REQ-006 Port blank_lz, input, 1: leading-zero blanking enable; sampled continuously, not latched.
REQ-007 Port seg, output, 7: active-high segments, seg[0]=a ... seg[6]=g.
REQ-008 Port an, output, 4: active-high one-hot digit enable, an[k] selects digit k.
REQ-009 Port err, output, 1: sticky flag for a captured non-BCD nibble.

Function
REQ-010 Prescaler shall count 0..PRESCALE-1 and wrap to 0; "tick" = cycle in which prescaler equals PRESCALE-1.
REQ-011 On tick, 2-bit digit index shall advance 0->1->2->3->0; "frame wrap" = tick with index 3.
REQ-012 Load shall write bcd_in into a pending register and set pending-valid; a later load before transfer shall overwrite pending (last write wins).
REQ-013 On frame wrap with pending-valid=1, the display register shall take the pending value and pending-valid shall clear; otherwise the display register shall hold.
REQ-014 Load coinciding with frame wrap shall write bcd_in directly into the display register, leave pending-valid=0, and discard any older pending value.
REQ-015 Display register shall change only at frame wrap (no mid-frame tearing).
REQ-016 an shall equal one-hot(index), derived from registered state only.
REQ-017 seg shall decode display digit at current index: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, bit0=a).
REQ-018 Nibble values 10..15 shall display as dash, seg=7'h40.
REQ-019 With blank_lz=1, digit k (k=3,2,1) shall display seg=7'h00 when digit k and every higher digit equal 0; digit 0 shall never be blanked.
REQ-020 A dash digit shall count as non-zero for blanking purposes.
REQ-021 err shall set on the edge where load=1 and any bcd_in nibble >9, and shall remain set until reset.
REQ-022 seg and an shall change only on the edge where index or display register changes (combinational on registered state, no input-to-output path except blank_lz to seg).
REQ-023 PRESCALE=1 shall advance the index every cycle.

Reset
REQ-024 rst=0 shall immediately force prescaler=0, index=0, display register=0, pending register=0, pending-valid=0, err=0, independent of clk.
REQ-025 During and directly after reset: an=4'b0001, seg=7'h3F, err=0.
REQ-026 Reset mid-frame shall discard pending data; the first tick after release shall occur PRESCALE cycles after the first clk edge with rst=1.

Verification (PRESCALE=4)
REQ-027 Assert rst=0 mid-cycle -> an=0001, seg=3F, err=0 without a clk edge; release -> index 1 after 4 edges.
REQ-028 load bcd_in=16'h1234 at index 1 -> display stays 0000 until frame wrap; next frame: index0 seg=66, index1 4F, index2 5B, index3 06.
REQ-029 blank_lz=1, display 16'h0070 -> an=1000 seg=00, an=0100 seg=00, an=0010 seg=07, an=0001 seg=3F; blank_lz=0 -> digits 3,2 show 3F.
REQ-030 load 16'h12A4 -> err=1 next edge; after wrap, digit 1 seg=40; subsequent valid load leaves err=1.
REQ-031 load 16'h5678 on the frame-wrap edge while pending holds 16'h1111 -> next frame shows 5678; 1111 never displayed; pending-valid=0.
REQ-032 Two loads (16'h0001 then 16'h0002) within one frame -> only 0002 displayed after wrap.
